// File: rtl/io_dmem_burst_reader_rr.sv
// io_dmem_burst_reader_rr: round-robin multi-channel burst reader in front of one DMem read port
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   req_read_addr/len/valid  per-channel burst request (start word address, length in words)
//   req_read_addr_ready      one-cycle accept pulse on the granted channel
//   resp_read_data/valid/last/ready  per-channel response beat stream
//   busy                     high from accept until the final beat is taken
//   dmem_addra/douta         DMem port A read path (1-cycle synchronous read)
//   dmem_dina/dmem_wea       tied off, the port is never written
module io_dmem_burst_reader_rr #(
    parameter int AWIDTH     = 14,
    parameter int DWIDTH     = 32,
    parameter int NUM_CH     = 2,
    parameter int IO_LATENCY = 10,
    parameter int LWIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*AWIDTH-1:0] req_read_addr,
    input  logic [NUM_CH*LWIDTH-1:0] req_read_len,
    input  logic [NUM_CH-1:0]        req_read_addr_valid,
    output logic [NUM_CH-1:0]        req_read_addr_ready,
    output logic [NUM_CH*DWIDTH-1:0] resp_read_data,
    output logic [NUM_CH-1:0]        resp_read_data_valid,
    output logic [NUM_CH-1:0]        resp_read_data_last,
    input  logic [NUM_CH-1:0]        resp_read_data_ready,
    output logic                     busy,
    output logic [AWIDTH-1:0]        dmem_addra,
    input  logic [DWIDTH-1:0]        dmem_douta,
    output logic [DWIDTH-1:0]        dmem_dina,
    output logic [3:0]               dmem_wea
);
    localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int WW = IO_LATENCY > 1 ? $clog2(IO_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, ACCEPT, WAIT, BURST} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       g_q, g_d;
    logic [CW-1:0]       ptr_q, ptr_d;
    logic [CW-1:0]       pick;
    logic [CW-1:0]       nxt_ptr;
    logic [AWIDTH-1:0]   addr_q;
    logic [LWIDTH-1:0]   rem_q;
    logic [WW-1:0]       wcnt_q;
    logic                d_valid_q;
    logic                d_last_q;
    logic [DWIDTH-1:0]   fdata_q [4];
    logic [3:0]          flast_q;
    logic [1:0]          wp_q;
    logic [1:0]          rp_q;
    logic [2:0]          cnt_q;
    logic [AWIDTH-1:0]   acc_addr;
    logic [LWIDTH-1:0]   acc_len;
    logic                acc_fire;
    logic                head_valid;
    logic                head_last;
    logic                pop;
    logic                issue;

    assign acc_addr   = req_read_addr[g_q*AWIDTH +: AWIDTH];
    assign acc_len    = req_read_len[g_q*LWIDTH +: LWIDTH];
    assign acc_fire   = (state_q == ACCEPT) && req_read_addr_valid[g_q];
    assign head_valid = cnt_q != 3'd0;
    assign head_last  = flast_q[rp_q];
    assign pop        = head_valid && resp_read_data_ready[g_q];
    assign nxt_ptr    = (g_q == CW'(NUM_CH - 1)) ? '0 : g_q + CW'(1);
    // A read is only launched while the 4-entry buffer can still hold it
    // alongside the beat already coming out of the RAM, so stalls never drop data.
    assign issue      = (state_q == BURST) && (rem_q != '0) && ((cnt_q + 3'(d_valid_q)) < 3'd4);

    // Scan from the pointer upward; walking the offsets downward leaves the
    // nearest valid channel as the winner.
    always_comb begin
        pick = ptr_q;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req_read_addr_valid[(int'(ptr_q) + i) % NUM_CH])
                pick = CW'((int'(ptr_q) + i) % NUM_CH);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            g_q     <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|req_read_addr_valid) begin
                    g_d     = pick;
                    state_d = ACCEPT;
                end
            end
            ACCEPT: begin
                if (!req_read_addr_valid[g_q]) begin
                    state_d = IDLE;
                end else if (acc_len == '0) begin
                    state_d = IDLE;
                    ptr_d   = nxt_ptr;
                end else begin
                    state_d = (IO_LATENCY == 0) ? BURST : WAIT;
                end
            end
            WAIT: begin
                if (wcnt_q == WW'(IO_LATENCY - 1))
                    state_d = BURST;
            end
            default: begin
                if (pop && head_last) begin
                    state_d = IDLE;
                    ptr_d   = nxt_ptr;
                end
            end
        endcase
    end

    always_comb begin
        req_read_addr_ready = '0;
        resp_read_data_valid = '0;
        resp_read_data_last  = '0;
        resp_read_data       = '0;
        req_read_addr_ready[g_q] = state_q == ACCEPT;
        resp_read_data_valid[g_q] = head_valid;
        resp_read_data_last[g_q]  = head_valid && head_last;
        resp_read_data[g_q*DWIDTH +: DWIDTH] = head_valid ? fdata_q[rp_q] : '0;
        busy       = (state_q == WAIT) || (state_q == BURST);
        dmem_addra = addr_q;
        dmem_dina  = '0;
        dmem_wea   = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q    <= '0;
            rem_q     <= '0;
            wcnt_q    <= '0;
            d_valid_q <= 1'b0;
            d_last_q  <= 1'b0;
            wp_q      <= '0;
            rp_q      <= '0;
            cnt_q     <= '0;
        end else begin
            if (acc_fire) begin
                addr_q <= acc_addr;
                rem_q  <= acc_len;
            end else if (issue) begin
                addr_q <= addr_q + AWIDTH'(1);
                rem_q  <= rem_q - LWIDTH'(1);
            end
            wcnt_q    <= (state_q == WAIT) ? wcnt_q + WW'(1) : '0;
            d_valid_q <= issue;
            d_last_q  <= issue && (rem_q == LWIDTH'(1));
            if (d_valid_q)
                wp_q <= wp_q + 2'd1;
            if (pop)
                rp_q <= rp_q + 2'd1;
            cnt_q <= cnt_q + 3'(d_valid_q) - 3'(pop);
        end
    end

    // RAM data lands one cycle after its address was issued.
    always_ff @(posedge clk) begin
        if (d_valid_q) begin
            fdata_q[wp_q] <= dmem_douta;
            flast_q[wp_q] <= d_last_q;
        end
    end
endmodule

// File: tb/tb_io_dmem_burst_reader_rr.sv
// tb_io_dmem_burst_reader_rr: scoreboard bench for the round-robin burst reader
module tb_io_dmem_burst_reader_rr;
    localparam int AW = 14, DW = 32, NC = 2, LAT = 10, LW = 32;

    typedef struct packed {
        int          ch;
        logic [31:0] d;
        logic        l;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NC*AW-1:0]  ra = '0;
    logic [NC*LW-1:0]  rl = '0;
    logic [NC-1:0]     rv = '0;
    logic [NC-1:0]     rr = '1;
    logic [NC-1:0]     rdy, vld, lst;
    logic [NC*DW-1:0]  rdata;
    logic              busy;
    logic [AW-1:0]     addra;
    logic [DW-1:0]     douta, dina;
    logic [3:0]        wea;
    logic [31:0]       mem [0:16383];
    beat_t             sb [$];
    beat_t             e_m;
    logic [NC-1:0]     pv = '0;
    logic [31:0]       pd [NC];
    logic              pl [NC];
    int                checks = 0, errors = 0, npop = 0, n0 = 0;

    io_dmem_burst_reader_rr #(.AWIDTH(AW), .DWIDTH(DW), .NUM_CH(NC), .IO_LATENCY(LAT), .LWIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .req_read_addr(ra), .req_read_len(rl), .req_read_addr_valid(rv), .req_read_addr_ready(rdy),
        .resp_read_data(rdata), .resp_read_data_valid(vld), .resp_read_data_last(lst),
        .resp_read_data_ready(rr), .busy(busy),
        .dmem_addra(addra), .dmem_douta(douta), .dmem_dina(dina), .dmem_wea(wea)
    );

    always #5 clk = ~clk;

    always @(posedge clk) douta <= mem[addra];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_burst(input int ch, input logic [13:0] a, input int l);
        logic [13:0] x;
        for (int i = 0; i < l; i++) begin
            x = a + 14'(i);
            sb.push_back('{ch, mem[x], i == l - 1});
        end
    endtask

    task automatic start_req(input int ch, input logic [13:0] a, input logic [31:0] l);
        ra[ch*AW +: AW] = a;
        rl[ch*LW +: LW] = l;
        rv[ch] = 1'b1;
    endtask

    task automatic wait_acc(input int ch);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (rdy[ch]) got = 1'b1;
        end
        chk("accept_seen", got, 1);
        if (got) begin
            @(posedge clk);
            #1;
        end
        rv[ch] = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
        chk("drain", sb.size(), 0);
        @(negedge clk);
        chk("busy_idle", busy, 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            pv = '0;
        end else begin
            chk("one_lane", $countones(vld) <= 1, 1);
            chk("last_wo_valid", lst & ~vld, 0);
            for (int k = 0; k < NC; k++) begin
                if (pv[k]) begin
                    chk("hold_valid", vld[k], 1);
                    chk("hold_data", rdata[k*DW +: DW], pd[k]);
                    chk("hold_last", lst[k], pl[k]);
                end
                if (vld[k] && rr[k]) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $error("FAIL extra_beat lane=%0d observed=%0h expected=none", k, rdata[k*DW +: DW]);
                    end else begin
                        e_m = sb.pop_front();
                        chk("beat_lane", k, e_m.ch);
                        chk("beat_data", rdata[k*DW +: DW], e_m.d);
                        chk("beat_last", lst[k], e_m.l);
                        npop++;
                    end
                end
                pv[k] = vld[k] && !rr[k];
                pd[k] = rdata[k*DW +: DW];
                pl[k] = lst[k];
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 32'hA500_0000 | 32'(i);
        for (int i = 0; i < 4; i++) mem[100 + i] = 32'(7 + i);
        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", rdy, 0);
        chk("rst_valid", vld, 0);
        chk("rst_last", lst, 0);
        chk("rst_data", rdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addra", addra, 0);
        rst = 1'b1;
        // simultaneous pair, pointer 0: ch0 then ch1
        push_burst(0, 14'd0, 3);
        push_burst(1, 14'd50, 2);
        start_req(0, 14'd0, 3);
        start_req(1, 14'd50, 2);
        wait_acc(0);
        wait_acc(1);
        wait_idle();
        // single channel latency and throughput
        push_burst(0, 14'd100, 4);
        start_req(0, 14'd100, 4);
        wait_acc(0);
        @(negedge clk);
        chk("busy_after_accept", busy, 1);
        chk("early_valid", vld, 0);
        for (int i = 0; i < LAT + 1; i++) begin
            @(negedge clk);
            chk("early_valid", vld, 0);
        end
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("burst_valid", vld[0], 1);
            chk("burst_data", rdata[31:0], 7 + j);
            chk("burst_last", lst[0], j == 3);
        end
        wait_idle();
        // pointer now 1: ch1 wins the next pair
        push_burst(1, 14'd60, 2);
        push_burst(0, 14'd10, 3);
        start_req(0, 14'd10, 3);
        start_req(1, 14'd60, 2);
        wait_acc(1);
        wait_acc(0);
        wait_idle();
        // backpressure with ready pattern 1,0,0
        push_burst(0, 14'd200, 8);
        start_req(0, 14'd200, 8);
        n0 = npop;
        wait_acc(0);
        for (int i = 0; i < 200 && sb.size() != 0; i++) begin
            rr[0] = (i % 3 == 0);
            @(posedge clk);
            #1;
        end
        rr = '1;
        chk("bp_beats", npop - n0, 8);
        wait_idle();
        repeat (4) begin
            @(negedge clk);
            chk("bp_quiet", vld, 0);
        end
        // address wrap
        push_burst(1, 14'd16382, 4);
        start_req(1, 14'd16382, 4);
        wait_acc(1);
        wait_idle();
        // zero length on ch1
        start_req(1, 14'd20, 0);
        wait_acc(1);
        @(negedge clk);
        chk("zero_ready_pulse", rdy, 0);
        chk("zero_busy", busy, 0);
        repeat (3) begin
            @(negedge clk);
            chk("zero_busy", busy, 0);
            chk("zero_no_beat", vld, 0);
        end
        push_burst(0, 14'd600, 3);
        start_req(0, 14'd600, 3);
        wait_acc(0);
        wait_idle();
        // reset after beat 2 of a len=10 burst (pointer is 1 here)
        push_burst(0, 14'd300, 10);
        start_req(0, 14'd300, 10);
        wait_acc(0);
        n0 = npop;
        for (int i = 0; i < 100 && npop < n0 + 3; i++) @(posedge clk);
        chk("rst_beats_before", npop - n0, 3);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_ready", rdy, 0);
        chk("mid_rst_valid", vld, 0);
        chk("mid_rst_last", lst, 0);
        chk("mid_rst_data", rdata, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_addra", addra, 0);
        sb.delete();
        rst = 1'b1;
        repeat (LAT + 6) begin
            @(negedge clk);
            chk("post_rst_quiet", vld, 0);
        end
        // fresh pair after reset: pointer back to 0, ch0 first
        push_burst(0, 14'd400, 3);
        push_burst(1, 14'd500, 2);
        start_req(0, 14'd400, 3);
        start_req(1, 14'd500, 2);
        wait_acc(0);
        wait_acc(1);
        wait_idle();
        chk("never_write_we", wea, 0);
        chk("never_write_din", dina, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
